// File: rtl/motor_pwm4_pkg.sv
// motor_pwm4_pkg: register map, measurement FSM states and bridge drive codes
package motor_pwm4_pkg;
  localparam logic [2:0] ADDR_CONT  = 3'd0;
  localparam logic [2:0] ADDR_TIME  = 3'd1;
  localparam logic [2:0] ADDR_DUTY0 = 3'd2;
  localparam logic [2:0] ADDR_REQ   = 3'd6;
  localparam logic [2:0] ADDR_MEAS  = 3'd7;
  typedef enum logic [1:0] {IDLE, WAIT_WRAP, DEAD, MEAS} measState_t;
  typedef enum logic [1:0] {COAST = 2'b00, FWD = 2'b01, REV = 2'b10, BRAKE = 2'b11} pwmCont_t;
  function automatic logic [1:0] lowIdx(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/motor_pwm4_pwm_channel.sv
// pwm_channel: one axis duty shadow/active pair and registered PWM compare
module pwm_channel
  import motor_pwm4_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          dutyWr,
  input  logic [TW-1:0] dutyIn,
  input  logic          wrap,
  input  logic [TW-1:0] count,
  output logic [TW-1:0] dutyBuf,
  output logic          pwm
);
  logic [TW-1:0] dutyAct;
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      dutyBuf <= '0;
      dutyAct <= '0;
      pwm     <= 1'b0;
    end else begin
      if (dutyWr) dutyBuf <= dutyIn;
      if (wrap) dutyAct <= dutyBuf;
      pwm <= count < dutyAct;
    end
  end
endmodule

// File: rtl/motor_pwm4.sv
// motor_pwm4: four-axis PWM generator with sequenced BEMF measurement windows
module motor_pwm4
  import motor_pwm4_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [2:0]  Addr,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic [3:0]  PwmOut,
  output logic [7:0]  PwmCont,
  output logic [3:0]  AxisActive,
  output logic [3:0]  AxisMeasure,
  input  logic        SampleDone,
  output logic        IntStatus,
  input  logic        IntReset
);
  logic [TW-1:0] period, prescale, dead, window, preCnt, count, dCnt;
  logic [TW-1:0] dutyBuf [4];
  logic [3:0] pending, timeout, reqWr, selMask, clrMask;
  logic [1:0] sel, dIdx;
  logic [15:0] rdMux;
  logic wrEn, tick, wrap, finish, success, keep, reqAgain;
  measState_t state;
  always_comb begin
    wrEn    = En && Wr;
    tick    = preCnt >= prescale;
    wrap    = tick && count >= period;
    reqWr   = (wrEn && Addr == ADDR_REQ) ? DataWr[3:0] : 4'b0;
    selMask = 4'b1 << sel;
    success = state == MEAS && SampleDone;
    finish  = state == MEAS && (SampleDone || dCnt == '0 || (tick && dCnt == TW'(1)));
    keep    = reqAgain || |(reqWr & selMask);
    clrMask = (finish && !keep) ? selMask : 4'b0;
    dIdx    = 2'(Addr - ADDR_DUTY0);
    rdMux   = Addr == ADDR_CONT ? 16'(PwmCont)
            : Addr == ADDR_TIME ? (16'(prescale) << 8) | 16'(period)
            : Addr == ADDR_REQ  ? {4'b0, state, sel, timeout, pending}
            : Addr == ADDR_MEAS ? (16'(window) << 8) | 16'(dead)
            : 16'(dutyBuf[dIdx]);
    DataRd  = (En && Rd) ? rdMux : 16'b0;
  end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    pwm_channel #(.TW(TW)) uCh (
      .Clk     (Clk),
      .ResetN  (ResetN),
      .dutyWr  (wrEn && Addr == ADDR_DUTY0 + 3'(i)),
      .dutyIn  (DataWr[TW-1:0]),
      .wrap    (wrap),
      .count   (count),
      .dutyBuf (dutyBuf[i]),
      .pwm     (PwmOut[i])
    );
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      preCnt <= '0;
      count  <= '0;
    end else begin
      preCnt <= tick ? '0 : preCnt + 1'b1;
      if (tick) count <= wrap ? '0 : count + 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      PwmCont  <= '0;
      period   <= '1;
      prescale <= '0;
      dead     <= '0;
      window   <= '0;
    end else if (wrEn) begin
      if (Addr == ADDR_CONT) PwmCont <= DataWr[7:0];
      if (Addr == ADDR_TIME) begin
        period   <= DataWr[TW-1:0];
        prescale <= DataWr[8 +: TW];
      end
      if (Addr == ADDR_MEAS) begin
        dead   <= DataWr[TW-1:0];
        window <= DataWr[8 +: TW];
      end
    end
  end
  // a re-request of the axis in service survives its completion so it is serviced again
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      sel         <= '0;
      dCnt        <= '0;
      pending     <= '0;
      timeout     <= '0;
      reqAgain    <= 1'b0;
      AxisActive  <= '1;
      AxisMeasure <= '0;
      IntStatus   <= 1'b0;
    end else begin
      pending   <= (pending & ~clrMask) | reqWr;
      IntStatus <= finish || (IntStatus && !IntReset);
      reqAgain  <= state != IDLE && !finish && keep;
      case (state)
        IDLE: if (|pending) begin
          sel   <= lowIdx(pending);
          state <= WAIT_WRAP;
        end
        WAIT_WRAP: if (wrap) begin
          AxisActive[sel] <= 1'b0;
          dCnt            <= dead;
          state           <= DEAD;
        end
        DEAD: if (dCnt == '0 || (tick && dCnt == TW'(1))) begin
          AxisMeasure[sel] <= 1'b1;
          dCnt             <= window;
          state            <= MEAS;
        end else if (tick) dCnt <= dCnt - 1'b1;
        MEAS: if (finish) begin
          AxisMeasure[sel] <= 1'b0;
          AxisActive[sel]  <= 1'b1;
          timeout[sel]     <= !success;
          state            <= IDLE;
        end else if (tick) dCnt <= dCnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_pwm4.sv
// tb_motor_pwm4: directed self-checking bench for motor_pwm4
module tb_motor_pwm4;
  import motor_pwm4_pkg::*;
  logic Clk, ResetN, En, Rd, Wr, SampleDone, IntStatus, IntReset;
  logic [2:0] Addr;
  logic [15:0] DataWr, DataRd, rdv;
  logic [3:0] PwmOut, AxisActive, AxisMeasure;
  logic [7:0] PwmCont;
  logic [9:0] pat;
  logic s [60];
  logic prev, found;
  int checks = 0, errors = 0, ones;

  motor_pwm4 #(.TW(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
    .En(En), .Rd(Rd), .Wr(Wr), .PwmOut(PwmOut), .PwmCont(PwmCont),
    .AxisActive(AxisActive), .AxisMeasure(AxisMeasure), .SampleDone(SampleDone),
    .IntStatus(IntStatus), .IntReset(IntReset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    Addr = a; DataWr = d; Wr = 1'b1;
    @(negedge Clk);
    Wr = 1'b0; Addr = 3'd6;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    Addr = a;
    #1 d = DataRd;
    Addr = 3'd6;
  endtask

  task automatic countOnes(input int b, input int n, output int o);
    o = 0;
    repeat (n) begin
      @(negedge Clk);
      o += int'(PwmOut[b]);
    end
  endtask

  task automatic findRise(input int b);
    found = 1'b0;
    prev = PwmOut[b];
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge Clk);
      found = !prev && PwmOut[b];
      prev = PwmOut[b];
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN = 1'b0; En = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 3'd6; DataWr = '0;
    SampleDone = 1'b0; IntReset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_pwmout", 16'(PwmOut), 16'h0);
    chk("rst_pwmcont", 16'(PwmCont), 16'h0);
    chk("rst_active", 16'(AxisActive), 16'hF);
    chk("rst_measure", 16'(AxisMeasure), 16'h0);
    chk("rst_int", 16'(IntStatus), 16'h0);
    ResetN = 1'b1;
    @(negedge Clk);
    rd(3'd1, rdv); chk("rst_addr1", rdv, 16'h00FF);
    rd(3'd6, rdv); chk("rst_addr6", rdv, 16'h0000);
    rd(3'd7, rdv); chk("rst_addr7", rdv, 16'h0000);

    wr(3'd0, 16'hFF00 | 16'({BRAKE, REV, FWD, COAST}));
    chk("pwmcont_applied", 16'(PwmCont), 16'h00E4);
    rd(3'd0, rdv); chk("pwmcont_readback", rdv, 16'h00E4);

    wr(3'd1, 16'h0009);
    wr(3'd2, 16'h0003);
    repeat (30) @(negedge Clk);
    countOnes(0, 20, ones); chk("d0_3_count", 16'(ones), 16'd6);
    findRise(0);
    chk("d0_3_rise_found", 16'(found), 16'h1);
    pat = 10'b1;
    for (int k = 1; k < 10; k++) begin
      @(negedge Clk);
      pat[k] = PwmOut[0];
    end
    chk("d0_3_pattern", 16'(pat), 16'h0007);
    chk("other_axes_idle", 16'(PwmOut[3:1]), 16'h0);
    wr(3'd2, 16'h000A);
    rd(3'd2, rdv); chk("d0_readback", rdv, 16'h000A);
    repeat (30) @(negedge Clk);
    countOnes(0, 20, ones); chk("d0_over_p_const1", 16'(ones), 16'd20);
    wr(3'd2, 16'h0000);
    repeat (30) @(negedge Clk);
    countOnes(0, 20, ones); chk("d0_zero_const0", 16'(ones), 16'd0);

    wr(3'd1, 16'h0109);
    wr(3'd3, 16'h0002);
    repeat (60) @(negedge Clk);
    findRise(1);
    chk("d1_rise_found", 16'(found), 16'h1);
    s[0] = 1'b1;
    for (int i = 1; i < 60; i++) begin
      if (i == 3) begin Addr = 3'd3; DataWr = 16'h0006; Wr = 1'b1; end
      if (i == 4) begin Wr = 1'b0; Addr = 3'd6; end
      @(negedge Clk);
      s[i] = PwmOut[1];
    end
    ones = 0; for (int i = 0; i < 20; i++) ones += int'(s[i]);
    chk("d1_first_period_ones", 16'(ones), 16'd4);
    ones = 0; for (int i = 20; i < 40; i++) ones += int'(s[i]);
    chk("d1_second_period_ones", 16'(ones), 16'd12);
    ones = 0; for (int i = 40; i < 60; i++) ones += int'(s[i]);
    chk("d1_third_period_ones", 16'(ones), 16'd12);
    chk("d1_pulse2_end", {14'b0, s[3], s[4]}, 16'b10);
    chk("d1_new_start", {14'b0, s[19], s[20]}, 16'b01);
    chk("d1_pulse6_end", {14'b0, s[31], s[32]}, 16'b10);

    wr(3'd1, 16'h0009);
    wr(3'd7, 16'h0502);
    wr(3'd6, 16'h0004);
    for (int i = 0; i < 40 && AxisActive !== 4'hB; i++) @(negedge Clk);
    chk("a2_active_released", 16'(AxisActive), 16'hB);
    chk("a2_measure_dead0", 16'(AxisMeasure), 16'h0);
    rd(3'd6, rdv); chk("a2_state_dead", rdv, 16'h0A04);
    @(negedge Clk);
    chk("a2_measure_dead1", 16'(AxisMeasure), 16'h0);
    @(negedge Clk);
    chk("a2_measure_set", 16'(AxisMeasure), 16'h4);
    rd(3'd6, rdv); chk("a2_state_meas", rdv, 16'h0E04);
    repeat (2) @(negedge Clk);
    chk("a2_int_before_done", 16'(IntStatus), 16'h0);
    SampleDone = 1'b1;
    @(negedge Clk);
    SampleDone = 1'b0;
    chk("a2_measure_clear", 16'(AxisMeasure), 16'h0);
    chk("a2_active_restored", 16'(AxisActive), 16'hF);
    chk("a2_int_set", 16'(IntStatus), 16'h1);
    rd(3'd6, rdv); chk("a2_status_after", rdv, 16'h0200);
    IntReset = 1'b1; @(negedge Clk); IntReset = 1'b0;
    chk("int_cleared", 16'(IntStatus), 16'h0);
    SampleDone = 1'b1; @(negedge Clk); SampleDone = 1'b0;
    @(negedge Clk);
    chk("stray_sampledone_int", 16'(IntStatus), 16'h0);

    wr(3'd6, 16'h0005);
    for (int i = 0; i < 40 && AxisActive !== 4'hE; i++) @(negedge Clk);
    chk("a0_active_released", 16'(AxisActive), 16'hE);
    repeat (2) @(negedge Clk);
    chk("a0_measure_set", 16'(AxisMeasure), 16'h1);
    repeat (4) @(negedge Clk);
    chk("a0_measure_before_to", 16'(AxisMeasure), 16'h1);
    @(negedge Clk);
    chk("a0_timeout_measure", 16'(AxisMeasure), 16'h0);
    chk("a0_timeout_active", 16'(AxisActive), 16'hF);
    chk("a0_timeout_int", 16'(IntStatus), 16'h1);
    rd(3'd6, rdv); chk("a0_timeout_status", rdv, 16'h0014);
    IntReset = 1'b1; @(negedge Clk); IntReset = 1'b0;
    chk("int_cleared2", 16'(IntStatus), 16'h0);
    for (int i = 0; i < 40 && AxisActive !== 4'hB; i++) @(negedge Clk);
    chk("a2b_active_released", 16'(AxisActive), 16'hB);
    repeat (2) @(negedge Clk);
    chk("a2b_measure_set", 16'(AxisMeasure), 16'h4);
    repeat (4) @(negedge Clk);
    IntReset = 1'b1;
    @(negedge Clk);
    IntReset = 1'b0;
    chk("int_set_dominant", 16'(IntStatus), 16'h1);
    rd(3'd6, rdv); chk("two_timeouts_status", rdv, 16'h0250);
    IntReset = 1'b1; @(negedge Clk); IntReset = 1'b0;

    wr(3'd6, 16'h0008);
    for (int i = 0; i < 40 && AxisActive !== 4'h7; i++) @(negedge Clk);
    chk("a3_active_released", 16'(AxisActive), 16'h7);
    @(negedge Clk);
    wr(3'd6, 16'h0008);
    for (int i = 0; i < 20 && AxisMeasure !== 4'h0; i++) @(negedge Clk);
    chk("a3_first_done", 16'(AxisMeasure), 16'h0);
    rd(3'd6, rdv); chk("a3_rerequest_pending", rdv & 16'h00FF, 16'h00D8);
    for (int i = 0; i < 40 && AxisMeasure !== 4'h8; i++) @(negedge Clk);
    chk("a3_serviced_again", 16'(AxisMeasure), 16'h8);
    for (int i = 0; i < 20 && AxisMeasure !== 4'h0; i++) @(negedge Clk);
    rd(3'd6, rdv); chk("a3_second_done", rdv & 16'h00FF, 16'h00D0);
    IntReset = 1'b1; @(negedge Clk); IntReset = 1'b0;

    wr(3'd6, 16'h0002);
    for (int i = 0; i < 40 && AxisMeasure !== 4'h2; i++) @(negedge Clk);
    chk("a1_measure_set", 16'(AxisMeasure), 16'h2);
    #2 ResetN = 1'b0;
    #1;
    chk("rstmeas_measure", 16'(AxisMeasure), 16'h0);
    chk("rstmeas_active", 16'(AxisActive), 16'hF);
    chk("rstmeas_int", 16'(IntStatus), 16'h0);
    chk("rstmeas_pwmcont", 16'(PwmCont), 16'h0);
    rd(3'd6, rdv); chk("rstmeas_status", rdv, 16'h0000);
    @(negedge Clk);
    ResetN = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rstmeas_no_int", 16'(IntStatus), 16'h0);
    chk("rstmeas_idle_measure", 16'(AxisMeasure), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/motor_pwm4.md
MOTOR_PWM4 -- requirements
Module: motor_pwm4

Interface
REQ-001 Parameter: TW, 8, width of the period, duty, prescale, dead-time and window fields.
REQ-002 Port: Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: ResetN  input  1  reset, asynchronous, active-low.
REQ-004 Port: Addr  input  3  word-register select.
REQ-005 Port: DataWr  input  16  bus write data.
REQ-006 Port: DataRd  output  16  bus read data, combinational mux of Addr.
REQ-007 Port: En, Rd, Wr  input  1 each  block select, read strobe, write strobe.
REQ-008 Port: PwmOut  output  4  per-axis PWM level.
REQ-009 Port: PwmCont  output  8  2 bits per axis: 00 coast, 01 fwd, 10 rev, 11 brake.
REQ-010 Port: AxisActive  output  4  1 = axis driven; 0 = axis released for BEMF.
REQ-011 Port: AxisMeasure  output  4  one-hot; sampler converts the flagged axis.
REQ-012 Port: SampleDone  input  1  one-clock pulse from the BEMF sampler.
REQ-013 Port: IntStatus  output  1  measurement-complete interrupt.
REQ-014 Port: IntReset  input  1  interrupt clear.

Function
REQ-015 Registers are written on the clock edge when En&Wr.
- 0: PwmCont[7:0].
- 1: [7:0] period P, [15:8] prescale S.
- 2..5: duty D0..D3 in [7:0].
- 6: measurement request bits [3:0] (OR into pending).
- 7: [7:0] dead count, [15:8] window count.
REQ-016 Read at Addr 6 returns: [3:0] pending, [7:4] timeout flags, [9:8] selected axis, [11:10] FSM state; other addresses return the written values, with unused bits 0.
REQ-017 Tick occurs every S+1 clocks.
- The period counter advances per tick, counting 0..P; it wraps to 0 after P and asserts wrap for that tick.
REQ-018 Duty is double-buffered: a written duty takes effect at the next wrap.
REQ-019 PwmOut[i] is registered and equals (count < Di), one clock after the count changes.
- Di=0 gives constant 0.
- Di>P gives constant 1.
REQ-020 PwmCont is applied one clock after the write, not synchronised to wrap.
REQ-021 The measurement FSM has four states: IDLE, WAIT_WRAP, DEAD, MEAS.
REQ-022 IDLE: when pending is nonzero, select the lowest-index pending axis and go to WAIT_WRAP.
REQ-023 WAIT_WRAP: on wrap, clear AxisActive[sel], load the dead count, go to DEAD.
REQ-024 DEAD: decrement per tick; at 0, set AxisMeasure[sel], load the window count, go to MEAS.
- Dead count 0 goes to MEAS on the next clock.
REQ-025 MEAS, SampleDone: clear AxisMeasure, pending[sel] and timeout[sel]; restore AxisActive[sel]; set IntStatus; go to IDLE.
REQ-026 MEAS, window decremented to 0 without SampleDone: same actions as REQ-025, but set timeout[sel].
- SampleDone in the same cycle as expiry counts as success.
REQ-027 SampleDone outside MEAS is ignored.
REQ-028 A request write for the currently selected axis during service leaves its pending bit set, so the axis is serviced again.
REQ-029 IntStatus is set-dominant: it stays 1 if IntReset and a set occur in the same clock.

Reset
REQ-030 While ResetN is low, outputs are forced immediately:
- PwmOut=0, PwmCont=0, AxisActive=4'hF, AxisMeasure=0, IntStatus=0.
- P=8'hFF, S=0, duties=0, dead=window=0.
- pending=0, timeouts=0, FSM=IDLE, counters=0.
REQ-031 Reset during DEAD or MEAS abandons the measurement with no interrupt.

Structure
REQ-032 A shared package holds the register address constants, the FSM state encoding and the PwmCont codes.
REQ-033 One sub-module, pwm_channel, holds one axis's duty buffer and PWM compare, instantiated 4 times.

Verification
REQ-034 Assert then release ResetN -> PwmOut=0, PwmCont=0, AxisActive=F, AxisMeasure=0, IntStatus=0, Addr 1 reads 16'h00FF.
REQ-035 P=9, S=0, D0=3 -> PwmOut[0] high 3 of every 10 clocks; D0=10 -> constant 1; D0=0 -> constant 0.
REQ-036 P=9, S=1, D1 changed 2->6 mid-period -> 2-tick high pulse completes, then 6-tick pulses from the next wrap.
REQ-037 Request 0x4, dead=2, window=5, S=0, SampleDone in 3rd MEAS clock:
- AxisActive=4'hB from wrap.
- AxisMeasure=4'h4 after 2 ticks.
- IntStatus=1, pending=0, timeout=0.
REQ-038 Request 0x5, no SampleDone:
- axis 0 times out after 5 ticks, then axis 2 is serviced.
- Addr 6 reads timeout=0x5 and pending=0.
- IntReset in the same clock as the second set leaves IntStatus=1.
REQ-039 ResetN low during MEAS -> AxisMeasure=0, AxisActive=F, FSM=IDLE immediately; IntStatus stays 0.
